vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Source end of the pixel-scan interface consumed by the renderer: generates x/y scan
//  coordinates, the active-video flag and the HSYNC/VSYNC pins for the VGA connector.
//  Default timing is 800x600@72Hz from a 50 MHz pixel clock. Also emits a once-per-frame
//  tick at the start of vertical blanking so game logic (ball/paddle/brick update) can run.
// PARAMETERS
//  H_ACTIVE   800   visible pixels per line
//  H_FP        56   horizontal front porch (pixels)
//  H_SYNC     120   horizontal sync width (pixels)
//  H_BP        64   horizontal back porch; H_TOTAL = sum of the four = 1040
//  V_ACTIVE   600   visible lines per frame
//  V_FP        37   vertical front porch (lines)
//  V_SYNC       6   vertical sync width (lines)
//  V_BP        23   vertical back porch; V_TOTAL = sum of the four = 666
//  H_POL        1   HSYNC asserted level (1 = positive sync)
//  V_POL        1   VSYNC asserted level
//  SYNC_DELAY   1   extra pipeline stages on sync/active (only with VGA_SYNC_DELAY_EN)
// PORTS
//  clk       in   1   pixel-domain clock
//  rst       in   1   asynchronous active-low reset
//  pix_ce    in   1   pixel clock enable; counters advance only on clk edges with pix_ce=1
//  x         out  11  horizontal counter, 0..H_TOTAL-1
//  y         out  10  vertical counter, 0..V_TOTAL-1
//  o_active  out  1   1 when x<H_ACTIVE && y<V_ACTIVE
//  hsync     out  1   horizontal sync pin
//  vsync     out  1   vertical sync pin
//  o_frame   out  1   one-clk pulse on entry to (x=0, y=V_ACTIVE)
// BEHAVIOUR
//  - All outputs registered on posedge clk; no combinational input-to-output paths.
//  - Reset (rst=0, async): x=H_TOTAL-1, y=V_TOTAL-1, o_active=0, hsync=!H_POL,
//    vsync=!V_POL, o_frame=0. Reset state equals the last blanking pixel, so the first
//    pix_ce after release produces x=0, y=0, o_active=1.
//  - On pix_ce: x<=x+1; if x==H_TOTAL-1 then x<=0 and y<=y+1 (y wraps V_TOTAL-1 -> 0).
//  - Flags are decoded from the NEXT counter value so they change on the same edge as
//    x/y (zero-cycle skew between coordinates and flags).
//  - hsync=H_POL iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (840..959 default).
//  - vsync=V_POL iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (637..642 default);
//    vsync changes only on the edge where x wraps to 0.
//  - o_frame: high exactly one clk on the edge where counters become (0,V_ACTIVE);
//    cleared on the next clk irrespective of pix_ce; never asserted twice per frame.
//  - pix_ce=0: x, y, o_active, hsync, vsync hold; o_frame drops after its one clk.
//  - Counter arithmetic is exact-width with explicit compare-and-wrap; no value outside
//    0..H_TOTAL-1 / 0..V_TOTAL-1 is ever driven, including immediately after reset.
//  - Reset mid-frame: outputs return to reset values asynchronously; scan restarts at
//    (0,0) on the first pix_ce after release; no o_frame for the aborted frame.
// CONFIGURATION
//  VGA_SYNC_DELAY_EN defined: hsync, vsync and o_active are additionally delayed by
//   SYNC_DELAY pix_ce-qualified register stages (reset to inactive), matching the
//   renderer's registered colour output; x, y and o_frame are not delayed.
//  Undefined: no delay stages; hsync/vsync/o_active aligned with x/y as above.
// TESTING
//  1 reset, pix_ce=1 constant -> first edge x=0,y=0,o_active=1; x=799 active, x=800 o_active=0.
//  2 run one line -> hsync high for exactly 120 clks starting at x=840; x wraps 1039->0, y+1.
//  3 run full frame -> vsync high 6 lines (y=637..642); y wraps 665->0; frame = 692640 clks.
//  4 count o_frame -> exactly 1 one-clk pulse per frame, at x=0,y=600.
//  5 pix_ce toggling 1/0 -> outputs hold on 0 cycles; frame takes 1385280 clks; o_frame 1 clk wide.
//  6 rst pulse at y=300 -> immediate reset values; restart at (0,0); VGA_SYNC_DELAY_EN build:
//    hsync/o_active lag x by SYNC_DELAY pix_ce steps.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA scan timing source: x/y coordinates, active flag, sync pins and a frame tick.
// Optional VGA_SYNC_DELAY_EN adds SYNC_DELAY pix_ce-qualified stages on hsync/vsync/o_active.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 800,
  parameter int   H_FP       = 56,
  parameter int   H_SYNC     = 120,
  parameter int   H_BP       = 64,
  parameter int   V_ACTIVE   = 600,
  parameter int   V_FP       = 37,
  parameter int   V_SYNC     = 6,
  parameter int   V_BP       = 23,
  parameter logic H_POL      = 1'b1,
  parameter logic V_POL      = 1'b1,
  parameter int   SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        o_active,
  output logic        hsync,
  output logic        vsync,
  output logic        o_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = SYNC_DELAY;
`else
  localparam int DLY = 0;
`endif

  logic [10:0] x_next;
  logic [9:0]  y_next;
  logic        active_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        frame_next;

  logic        active_reg;
  logic        hsync_reg;
  logic        vsync_reg;

  // Flags are decoded from the next coordinates so they land on the same edge as x/y.
  always_comb begin
    x_next = (x == H_LAST) ? 11'd0 : x + 11'd1;
    y_next = y;
    if (x == H_LAST) begin
      y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
    end
    active_next = (x_next < H_ACT) && (y_next < V_ACT);
    hsync_next  = ((x_next >= H_HS_START) && (x_next < H_HS_END)) ? H_POL : ~H_POL;
    vsync_next  = ((y_next >= V_VS_START) && (y_next < V_VS_END)) ? V_POL : ~V_POL;
    frame_next  = (x_next == 11'd0) && (y_next == V_ACT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x          <= H_LAST;
      y          <= V_LAST;
      active_reg <= 1'b0;
      hsync_reg  <= ~H_POL;
      vsync_reg  <= ~V_POL;
      o_frame    <= 1'b0;
    end else begin
      o_frame <= pix_ce && frame_next;
      if (pix_ce) begin
        x          <= x_next;
        y          <= y_next;
        active_reg <= active_next;
        hsync_reg  <= hsync_next;
        vsync_reg  <= vsync_next;
      end
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign o_active = active_reg;
      assign hsync    = hsync_reg;
      assign vsync    = vsync_reg;
    end else begin : g_dly
      logic act_pipe [0:DLY];
      logic hs_pipe  [0:DLY];
      logic vs_pipe  [0:DLY];

      assign act_pipe[0] = active_reg;
      assign hs_pipe[0]  = hsync_reg;
      assign vs_pipe[0]  = vsync_reg;

      for (genvar gi = 0; gi < DLY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            act_pipe[gi+1] <= 1'b0;
            hs_pipe[gi+1]  <= ~H_POL;
            vs_pipe[gi+1]  <= ~V_POL;
          end else if (pix_ce) begin
            act_pipe[gi+1] <= act_pipe[gi];
            hs_pipe[gi+1]  <= hs_pipe[gi];
            vs_pipe[gi+1]  <= vs_pipe[gi];
          end
        end
      end

      assign o_active = act_pipe[DLY];
      assign hsync    = hs_pipe[DLY];
      assign vsync    = vs_pipe[DLY];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a shrunken timing so whole frames fit the run.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic HPOL = 1'b1;
  localparam logic VPOL = 1'b1;
  localparam int SDLY = 1;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = SDLY;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        fr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_ce = 1'b1;
  logic [10:0] x;
  logic [9:0]  y;
  logic        o_active, hsync, vsync, o_frame;

  int checks = 0;
  int errors = 0;

  exp_t sb [$];
  logic [2:0] hist [$];
  int   mx, my;
  logic [2:0] cur_flags;

  // observation statistics, cleared by each scenario
  int cyc = 0;
  int fr_cnt, prev_fr_cyc, fr_period, first_fr_cyc;
  int hs_clks, hs_first_x, vs_clks, vs_first_y, y_wraps;
  logic prev_fr_obs, double_fr;
  logic [9:0] prev_y;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL), .SYNC_DELAY(SDLY)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .x(x), .y(y), .o_active(o_active),
    .hsync(hsync), .vsync(vsync), .o_frame(o_frame)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = HT - 1;
    my = VT - 1;
    cur_flags = {1'b0, ~HPOL, ~VPOL};
    hist.delete();
    for (int i = 0; i < DLY; i++) hist.push_back({1'b0, ~HPOL, ~VPOL});
    sb.delete();
  endtask

  task automatic clear_stats();
    fr_cnt = 0; prev_fr_cyc = -1; fr_period = -1; first_fr_cyc = -1;
    hs_clks = 0; hs_first_x = -1; vs_clks = 0; vs_first_y = -1; y_wraps = 0;
    prev_fr_obs = 1'b0; double_fr = 1'b0; prev_y = y;
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step(input logic ce);
    exp_t e;
    logic [2:0] f;
    logic efr;
    pix_ce = ce;
    efr = 1'b0;
    if (ce) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      f[2] = (mx < HA) && (my < VA);
      f[1] = (mx >= HA + HF && mx < HA + HF + HS) ? HPOL : ~HPOL;
      f[0] = (my >= VA + VF && my < VA + VF + VS) ? VPOL : ~VPOL;
      if (DLY == 0) begin
        cur_flags = f;
      end else begin
        hist.push_back(f);
        cur_flags = hist.pop_front();
      end
      efr = (mx == 0) && (my == VA);
    end
    e = '{x: 11'(mx), y: 10'(my), act: cur_flags[2], hs: cur_flags[1], vs: cur_flags[0], fr: efr};
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    checks++;
    if (x !== e.x || y !== e.y || o_active !== e.act || hsync !== e.hs ||
        vsync !== e.vs || o_frame !== e.fr) begin
      errors++;
      $display("FAIL scan cyc=%0d got x=%0d y=%0d act=%b hs=%b vs=%b fr=%b exp x=%0d y=%0d act=%b hs=%b vs=%b fr=%b",
               cyc, x, y, o_active, hsync, vsync, o_frame, e.x, e.y, e.act, e.hs, e.vs, e.fr);
    end
    if (o_frame) begin
      fr_cnt++;
      if (first_fr_cyc < 0) first_fr_cyc = cyc;
      if (prev_fr_cyc >= 0) fr_period = cyc - prev_fr_cyc;
      prev_fr_cyc = cyc;
    end
    if (o_frame && prev_fr_obs) double_fr = 1'b1;
    prev_fr_obs = o_frame;
    if (ce && hsync === HPOL) begin
      hs_clks++;
      if (hs_first_x < 0) hs_first_x = int'(x);
    end
    if (ce && vsync === VPOL) begin
      vs_clks++;
      if (vs_first_y < 0) vs_first_y = int'(y);
    end
    if (prev_y == 10'(VT - 1) && y == 10'd0) y_wraps++;
    prev_y = y;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (x !== 11'(HT - 1) || y !== 10'(VT - 1) || o_active !== 1'b0 ||
        hsync !== ~HPOL || vsync !== ~VPOL || o_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got x=%0d y=%0d act=%b hs=%b vs=%b fr=%b", x, y, o_active, hsync, vsync, o_frame);
    end
    model_reset();
    rst = 1'b1;
    clear_stats();
    step(1'b1);
    checks++;
    if (x !== 11'd0 || y !== 10'd0 || o_active !== 1'b1) begin
      errors++;
      $display("FAIL first_pixel got x=%0d y=%0d act=%b exp 0 0 1", x, y, o_active);
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_line();
    // from (0,0): walk to x=HA-1, then one more for the active boundary
    for (int i = 0; i < HA - 1; i++) step(1'b1);
    checks++;
    if (x !== 11'(HA - 1) || o_active !== 1'b1) begin
      errors++;
      $display("FAIL active_last got x=%0d act=%b exp x=%0d act=1", x, o_active, HA - 1);
    end
    step(1'b1);
    checks++;
    if (x !== 11'(HA) || o_active !== 1'b0) begin
      errors++;
      $display("FAIL active_end got x=%0d act=%b exp x=%0d act=0", x, o_active, HA);
    end
    for (int i = 0; i < HT - HA; i++) step(1'b1);
    checks++;
    if (x !== 11'd0 || y !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap got x=%0d y=%0d exp 0 1", x, y);
    end
    checks++;
    if (hs_clks != HS || hs_first_x != HA + HF + DLY) begin
      errors++;
      $display("FAIL hsync_width got clks=%0d first_x=%0d exp %0d %0d", hs_clks, hs_first_x, HS, HA + HF + DLY);
    end
    $display("test_line done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_frame();
    clear_stats();
    for (int i = 0; i < 2 * FRAME; i++) step(1'b1);
    checks++;
    if (vs_clks != 2 * VS * HT || vs_first_y != VA + VF) begin
      errors++;
      $display("FAIL vsync_width got clks=%0d first_y=%0d exp %0d %0d", vs_clks, vs_first_y, 2 * VS * HT, VA + VF);
    end
    checks++;
    if (y_wraps != 2) begin
      errors++;
      $display("FAIL y_wrap got %0d exp 2", y_wraps);
    end
    checks++;
    if (fr_cnt != 2 || fr_period != FRAME || double_fr) begin
      errors++;
      $display("FAIL frame_tick got cnt=%0d period=%0d double=%b exp 2 %0d 0", fr_cnt, fr_period, double_fr, FRAME);
    end
    $display("test_frame done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_ce_toggle();
    clear_stats();
    for (int i = 0; i < 4 * FRAME; i++) step(i[0] == 1'b0);
    checks++;
    if (fr_cnt != 2 || fr_period != 2 * FRAME || double_fr) begin
      errors++;
      $display("FAIL ce_frame got cnt=%0d period=%0d double=%b exp 2 %0d 0", fr_cnt, fr_period, double_fr, 2 * FRAME);
    end
    $display("test_ce_toggle done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid();
    int n;
    int rel_cyc;
    n = 0;
    while (!(y == 10'(VA / 2) && x == 11'd3) && n < 2 * FRAME) begin
      step(1'b1);
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("FAIL reach_mid timeout x=%0d y=%0d", x, y);
    end
    pix_ce = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (x !== 11'(HT - 1) || y !== 10'(VT - 1) || o_active !== 1'b0 ||
        hsync !== ~HPOL || vsync !== ~VPOL || o_frame !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d act=%b hs=%b vs=%b fr=%b", x, y, o_active, hsync, vsync, o_frame);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (x !== 11'(HT - 1) || y !== 10'(VT - 1) || o_frame !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got x=%0d y=%0d fr=%b", x, y, o_frame);
    end
    model_reset();
    rst = 1'b1;
    clear_stats();
    rel_cyc = cyc;
    step(1'b1);
    checks++;
    if (x !== 11'd0 || y !== 10'd0) begin
      errors++;
      $display("FAIL restart got x=%0d y=%0d exp 0 0", x, y);
    end
    for (int i = 0; i < FRAME; i++) step(1'b1);
    checks++;
    if (fr_cnt != 1 || first_fr_cyc - rel_cyc != VA * HT + 1) begin
      errors++;
      $display("FAIL restart_frame got cnt=%0d at=%0d exp 1 %0d", fr_cnt, first_fr_cyc - rel_cyc, VA * HT + 1);
    end
    $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_ce_toggle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
